// File: rtl/uart_word_tx.sv
// UART transmitter for multi-byte words, least-significant byte first.
// Each frame is start(0), DATA_BITS data bits LSB first, an optional parity bit, then
// STOP_BITS stop bits(1). A one-word holding register lets the next word be accepted while the
// current one shifts out, so streamed words follow each other with no idle bits.
//
// Ports:
//   baud_clk    - single clock, rising edge
//   rst         - synchronous active-high reset
//   data_in     - word to send, byte 0 in data_in[DATA_BITS-1:0]
//   send_valid  - data_in valid
//   send_ready  - word can be accepted this cycle (combinational)
//   data_tx     - serial line, idle high (registered)
//   active_flag - high while a frame bit is on the line (registered)
//   done_flag   - one-cycle pulse after the last stop bit of each word (registered)
module uart_word_tx #(
  parameter int unsigned NUM_BYTES    = 3,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                            baud_clk,
  input  logic                            rst,
  input  logic [NUM_BYTES*DATA_BITS-1:0]  data_in,
  input  logic                            send_valid,
  output logic                            send_ready,
  output logic                            data_tx,
  output logic                            active_flag,
  output logic                            done_flag
);

  localparam int unsigned WordW = NUM_BYTES * DATA_BITS;
  localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam int unsigned ByteW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic        OddPar = (PARITY == 2);

  if (PARITY > 2) begin : g_bad_parity
    $error("uart_word_tx: PARITY must be 0, 1 or 2");
  end
  if (NUM_BYTES < 1 || NUM_BYTES > 8) begin : g_bad_bytes
    $error("uart_word_tx: NUM_BYTES must be 1..8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
    $error("uart_word_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_word_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks
    $error("uart_word_tx: CLKS_PER_BIT must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_q, bit_d;     // data bit index, reused as stop bit index
  logic [ByteW-1:0]     byte_q, byte_d;
  logic [WordW-1:0]     shift_q, shift_d;
  logic                 par_q, par_d;
  logic [WordW-1:0]     hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic                 tx_q, tx_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

  logic tick, last_data, last_stop, last_byte, word_end, accept;

  assign tick      = (cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign last_data = (bit_q == BitW'(DATA_BITS - 1));
  assign last_stop = (bit_q == BitW'(STOP_BITS - 1));
  assign last_byte = (byte_q == ByteW'(NUM_BYTES - 1));
  assign word_end  = (state_q == StStop) && tick && last_stop && last_byte;

  // A full holding register frees up on the word_end edge, so a new word may land in it then.
  assign send_ready = !rst && (!hold_vld_q || word_end);
  assign accept     = send_valid && send_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    shift_d    = shift_q;
    par_d      = par_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    done_d     = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StStart;
          shift_d = data_in;
          byte_d  = '0;
          bit_d   = '0;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          bit_d   = '0;
          par_d   = 1'b0;
        end
      end
      StData: begin
        if (tick) begin
          // Consumed bits shift out, leaving the next byte's bit 0 at the bottom.
          shift_d = shift_q >> 1;
          par_d   = par_q ^ shift_q[0];
          if (last_data) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d = StStop;
          bit_d   = '0;
        end
      end
      StStop: begin
        if (tick) begin
          if (!last_stop) begin
            bit_d = bit_q + BitW'(1);
          end else begin
            bit_d = '0;
            if (!last_byte) begin
              byte_d  = byte_q + ByteW'(1);
              state_d = StStart;
            end else begin
              done_d = 1'b0 | 1'b1;
              byte_d = '0;
              if (hold_vld_q) begin
                shift_d = hold_q;
                state_d = StStart;
              end else if (accept) begin
                // Word offered on the final stop edge goes straight to the shifter.
                shift_d = data_in;
                state_d = StStart;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (word_end && hold_vld_q) begin
      hold_vld_d = 1'b0;
    end
    if (accept && (state_q != StIdle) && !(word_end && !hold_vld_q)) begin
      hold_d     = data_in;
      hold_vld_d = 1'b1;
    end

    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d ^ OddPar;
      default:  tx_d = 1'b1;
    endcase
    active_d = (state_d != StIdle);
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      tx_q       <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      tx_q       <= tx_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign data_tx     = tx_q;
  assign active_flag = active_q;
  assign done_flag   = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: three differently configured instances driven with directed and
// random words, checked cycle by cycle against a frame-arithmetic reference model.
module tb_uart_word_tx;

  localparam int N = 3;
  localparam int NB  [N] = '{3, 2, 1};
  localparam int DB  [N] = '{8, 7, 5};
  localparam int PAR [N] = '{0, 2, 1};
  localparam int SB  [N] = '{1, 2, 1};
  localparam int CPB [N] = '{1, 3, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] din   [N];
  logic        valid [N];
  logic        ready [N];
  logic        tx    [N];
  logic        act   [N];
  logic        done  [N];

  always #5 clk = ~clk;

  uart_word_tx #(
    .NUM_BYTES(NB[0]), .DATA_BITS(DB[0]), .PARITY(PAR[0]), .STOP_BITS(SB[0]),
    .CLKS_PER_BIT(CPB[0])
  ) u_dut0 (
    .baud_clk(clk), .rst(rst), .data_in(din[0][23:0]), .send_valid(valid[0]),
    .send_ready(ready[0]), .data_tx(tx[0]), .active_flag(act[0]), .done_flag(done[0])
  );

  uart_word_tx #(
    .NUM_BYTES(NB[1]), .DATA_BITS(DB[1]), .PARITY(PAR[1]), .STOP_BITS(SB[1]),
    .CLKS_PER_BIT(CPB[1])
  ) u_dut1 (
    .baud_clk(clk), .rst(rst), .data_in(din[1][13:0]), .send_valid(valid[1]),
    .send_ready(ready[1]), .data_tx(tx[1]), .active_flag(act[1]), .done_flag(done[1])
  );

  uart_word_tx #(
    .NUM_BYTES(NB[2]), .DATA_BITS(DB[2]), .PARITY(PAR[2]), .STOP_BITS(SB[2]),
    .CLKS_PER_BIT(CPB[2])
  ) u_dut2 (
    .baud_clk(clk), .rst(rst), .data_in(din[2][4:0]), .send_valid(valid[2]),
    .send_ready(ready[2]), .data_tx(tx[2]), .active_flag(act[2]), .done_flag(done[2])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a word in flight is just its data plus a cycle offset t into it.
  bit          busy      [N];
  int          t         [N];
  logic [63:0] cur       [N];
  logic [63:0] hold      [N];
  bit          hold_full [N];
  bit          done_exp  [N];
  bit          acc       [N];

  function automatic int frame_len(int i);
    return 1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i];
  endfunction

  function automatic int word_len(int i);
    return NB[i] * frame_len(i) * CPB[i];
  endfunction

  function automatic logic [63:0] word_mask(int i);
    return (64'd1 << (NB[i] * DB[i])) - 64'd1;
  endfunction

  function automatic logic exp_line(int i);
    int f, b, byt;
    logic [63:0] val;
    if (!busy[i]) return 1'b1;
    f   = frame_len(i);
    b   = (t[i] / CPB[i]) % f;
    byt = t[i] / (CPB[i] * f);
    val = (cur[i] >> (byt * DB[i])) & ((64'd1 << DB[i]) - 64'd1);
    if (b == 0) return 1'b0;
    if (b <= DB[i]) return val[b-1];
    if (b == DB[i] + 1 && PAR[i] != 0) return (^val) ^ (PAR[i] == 2);
    return 1'b1;
  endfunction

  task automatic step();
    logic [63:0] snap [N];
    bit          exp_rdy;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      exp_rdy = !rst && (!hold_full[i] || (busy[i] && t[i] == word_len(i) - 1));
      check_eq($sformatf("d%0d.ready", i), {63'd0, ready[i]}, {63'd0, exp_rdy});
      acc[i]  = valid[i] && exp_rdy;
      snap[i] = din[i] & word_mask(i);
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      done_exp[i] = 1'b0;
      if (rst) begin
        busy[i]      = 1'b0;
        hold_full[i] = 1'b0;
      end else begin
        if (busy[i]) begin
          t[i]++;
          if (t[i] == word_len(i)) begin
            busy[i]     = 1'b0;
            done_exp[i] = 1'b1;
            if (hold_full[i]) begin
              cur[i]       = hold[i];
              busy[i]      = 1'b1;
              t[i]         = 0;
              hold_full[i] = 1'b0;
            end
          end
        end
        if (acc[i]) begin
          if (!busy[i]) begin
            cur[i]  = snap[i];
            busy[i] = 1'b1;
            t[i]    = 0;
          end else begin
            hold[i]      = snap[i];
            hold_full[i] = 1'b1;
          end
        end
      end
    end
    #1;
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("d%0d.tx", i), {63'd0, tx[i]}, {63'd0, exp_line(i)});
      check_eq($sformatf("d%0d.active", i), {63'd0, act[i]}, {63'd0, busy[i]});
      check_eq($sformatf("d%0d.done", i), {63'd0, done[i]}, {63'd0, done_exp[i]});
    end
  endtask

  task automatic randomize_din();
    for (int i = 0; i < N; i++) din[i] = {$urandom, $urandom};
  endtask

  initial begin
    int  n_acc [N];
    bit  any_busy;

    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      valid[i] = 1'b0;
      din[i]   = '0;
      busy[i]  = 1'b0;
      t[i]     = 0;
      hold_full[i] = 1'b0;
    end
    repeat (3) step();
    rst = 1'b0;

    // Single known words from idle; data_in scrambled right after acceptance.
    din[0] = 64'hA5C33C;
    din[1] = 64'h2AD5;      // two bytes of 0x55 at 7 bits
    din[2] = 64'h15;
    for (int i = 0; i < N; i++) valid[i] = 1'b1;
    step();
    for (int i = 0; i < N; i++) valid[i] = 1'b0;
    for (int k = 0; k < 75; k++) begin
      randomize_din();
      step();
    end

    // Two words streamed with valid held high: 0x..01 then all-ones-but-bit0.
    for (int i = 0; i < N; i++) begin
      n_acc[i] = 0;
      din[i]   = 64'd1;
      valid[i] = 1'b1;
    end
    for (int k = 0; k < 200; k++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          n_acc[i]++;
          if (n_acc[i] == 1) din[i] = word_mask(i) & ~64'd1;
          else valid[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < N; i++) check_eq($sformatf("d%0d.stream_acc", i), n_acc[i], 2);

    // Fill shifter and holding register, then reset mid-word.
    for (int i = 0; i < N; i++) valid[i] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      randomize_din();
      step();
    end
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Random traffic with occasional resets and valid toggling while not ready.
    for (int k = 0; k < 1500; k++) begin
      randomize_din();
      for (int i = 0; i < N; i++) valid[i] = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0;

    // Drain, bounded.
    for (int i = 0; i < N; i++) valid[i] = 1'b0;
    any_busy = 1'b1;
    for (int k = 0; k < 400 && any_busy; k++) begin
      step();
      any_busy = 1'b0;
      for (int i = 0; i < N; i++) if (busy[i] || hold_full[i]) any_busy = 1'b1;
    end
    check_eq("drain_idle", {63'd0, any_busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Parametrised UART transmitter that serialises a multi-byte word (default one 24-bit RGB pixel) as consecutive UART frames, least-significant byte first. It is the next-generation transmit block of the image-processing datapath: it adds configurable byte count, data width, parity, stop bits and bit period, plus a valid/ready input handshake. A one-word holding register lets the next pixel be accepted while the current one shifts out, so streamed words go back-to-back with no idle gap.

## Interface
- NUM_BYTES, 3, frames per word (1..8)
- DATA_BITS, 8, data bits per frame (5..8)
- PARITY, 0, 0 none, 1 even, 2 odd; any other value fails elaboration
- STOP_BITS, 1, stop bits per frame (1 or 2)
- CLKS_PER_BIT, 1, baud_clk cycles per serial bit (≥1)
- baud_clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  NUM_BYTES*DATA_BITS  word to send; byte 0 = data_in[DATA_BITS-1:0]
- send_valid  in  1  data_in valid
- send_ready  out  1  holding register empty and rst low (combinational)
- data_tx  out  1  serial line, idle high (registered)
- active_flag  out  1  high while any frame bit is on the line (registered)
- done_flag  out  1  one-cycle pulse at the end of each word (registered)

## Operation
- Reset values: data_tx=1, active_flag=0, done_flag=0; holding register empty; state IDLE; send_ready=0 while rst=1.
- Handshake: word accepted at the rising edge where send_valid && send_ready. data_in is captured then and may change afterwards. send_valid is ignored while send_ready=0 or rst=1.
- If IDLE at acceptance, the word loads straight into the shifter and the holding register stays empty. Otherwise it goes into the holding register, and send_ready drops until the holding register is emptied.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance.
  - START -> DATA after 1 bit.
  - DATA -> PARITY (PARITY≠0) or STOP after DATA_BITS bits.
  - PARITY -> STOP after 1 bit.
  - STOP -> START after STOP_BITS bits if more bytes remain in the word.
  - At the end of the last byte's STOP: START with the holding word if one is present (holding register emptied at that edge), else IDLE.
- Frame bits: start=0; data LSB first; parity = XOR of the data bits (even) or its inverse (odd); stop=1.
- Counters: bit-period counter 0..CLKS_PER_BIT-1; bit index 0..DATA_BITS-1; byte index 0..NUM_BYTES-1. All wrap to 0 at state or byte change.
- active_flag=1 in every state except IDLE.
- done_flag pulses on the first cycle after the final stop bit of every word, whether the line goes idle or the next word's start bit follows.
- Acceptance in the same cycle the holding word transfers to the shifter is allowed: the new word enters the freed holding register. send_ready is combinational, so it already reads 1 in that cycle.
- Reset mid-word aborts immediately: data_tx=1 the next cycle, holding word discarded, no done_flag.

## Timing
- Bits per frame F = 1+DATA_BITS+(PARITY≠0)+STOP_BITS; word duration W = NUM_BYTES*F*CLKS_PER_BIT cycles. Default W=30.
- Acceptance edge N (from IDLE): start bit on data_tx during cycles N+1..N+CLKS_PER_BIT; active_flag=1 from cycle N+1.
- Last stop bit ends at cycle N+W. done_flag=1 in cycle N+W+1.
  - No pending word: active_flag=0 in that cycle and data_tx=1.
  - Pending word: its start bit occupies cycle N+W+1, with active_flag continuous.
- Byte boundaries inside a word have no idle bits.
- Minimum turnaround IDLE->accept->start: one edge.

## Test plan
- Default params, accept 0xA5C33C from IDLE -> line carries frames 3C, C3, A5, each 0,data LSB-first,1; active_flag high exactly 30 cycles; done_flag single pulse at cycle 31.
- Two words streamed: valid held high with 0x000001 then 0xFFFFFE -> second accepted while active, send_ready low until transfer, 60 contiguous active cycles, data_tx never idles between words, two done_flag pulses 30 cycles apart.
- PARITY=1 then PARITY=2, DATA_BITS=7, byte 0x55 -> parity bit 0 (even) / 1 (odd); F=10.
- STOP_BITS=2, CLKS_PER_BIT=4, NUM_BYTES=1, byte 0x80 -> each bit held 4 cycles, 11 bits, W=44, two stop bits high.
- Reset asserted mid-data of byte 1 with a word pending -> next cycle data_tx=1, active_flag=0, no done_flag; send_ready 0 during rst, 1 after; a fresh word then transmits correctly.
- Valid toggled while send_ready=0 -> no capture; data_in changed after acceptance -> transmitted word unchanged.
